// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared requester IDs, FSM states and default widths for the memory port arbiter
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INT  = 2'd1,
    OWN_DM   = 2'd2,
    OWN_IF   = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Grant vector layout is {if, dm, int}.
  function automatic owner_t grant_to_owner(input logic [2:0] grant);
    owner_t own;
    if (grant[0])      own = OWN_INT;
    else if (grant[1]) own = OWN_DM;
    else if (grant[2]) own = OWN_IF;
    else               own = OWN_NONE;
    return own;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-macro signals of the shared memory port
interface mem_port_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              int_req;
  logic [ADDR_W-1:0] int_addr;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              int_done;
  logic              dm_done;
  logic              if_done;
  logic [DATA_W-1:0] rdata;
  logic              int_stall;
  logic              dm_stall;
  logic              if_stall;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;

  modport slave (
    input  int_req, int_addr, dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr, m_rdata,
    output int_done, dm_done, if_done, rdata, int_stall, dm_stall, if_stall,
           m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output int_req, int_addr, dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr, m_rdata,
    input  int_done, dm_done, if_done, rdata, int_stall, dm_stall, if_stall,
           m_en, m_we, m_addr, m_wdata, busy
  );

endinterface

// File: rtl/arb_prio_starve.sv
// rtl/arb_prio_starve.sv - fixed INT > DM > IF priority with a starvation boost lifting IF above DM
module arb_prio_starve
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_arb_en,
  input  logic       i_int_req,
  input  logic       i_dm_req,
  input  logic       i_if_req,
  output logic [2:0] o_grant
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_boost;

  assign w_boost = (r_starve_cnt >= CNT_W'(STARVE_MAX));

  always_comb begin
    o_grant = 3'b000;
    if (i_int_req)             o_grant = 3'b001;
    else if (i_if_req && w_boost) o_grant = 3'b100;
    else if (i_dm_req)         o_grant = 3'b010;
    else if (i_if_req)         o_grant = 3'b100;
  end

  // Counts consecutive lost arbitrations while IF keeps asking; saturates at the boost level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (!i_if_req) begin
      r_starve_cnt <= '0;
    end else if (i_arb_en) begin
      if (o_grant[2])    r_starve_cnt <= '0;
      else if (!w_boost) r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-transaction-at-a-time arbiter for the unified instruction/data memory
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int LAT_W = 2;

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_m_en;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        w_grant;
  logic              w_arb_en;
  logic              w_last;
  logic [ADDR_W-1:0] w_sel_addr;

  assign w_arb_en = (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_WAIT) && (r_lat_cnt == '0);

  arb_prio_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_arb_en  (w_arb_en),
    .i_int_req (bus.int_req),
    .i_dm_req  (bus.dm_req),
    .i_if_req  (bus.if_req),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_sel_addr = bus.if_addr;
    if (w_grant[0])      w_sel_addr = bus.int_addr;
    else if (w_grant[1]) w_sel_addr = bus.dm_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|w_grant) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_WAIT;
      ST_WAIT:   if (r_lat_cnt == '0) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Address/data are latched at grant so requester changes mid-transaction are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_NONE;
      r_lat_cnt <= '0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_rdata   <= '0;
    end else begin
      r_m_en <= 1'b0;
      r_m_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner   <= grant_to_owner(w_grant);
            r_m_en    <= 1'b1;
            r_m_we    <= w_grant[1] & bus.dm_we;
            r_m_addr  <= w_sel_addr;
            r_m_wdata <= w_grant[1] ? bus.dm_wdata : '0;
          end
        end
        ST_ACCESS: r_lat_cnt <= LAT_W'(MEM_LAT - 1);
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_rdata <= bus.m_rdata;
            r_owner <= OWN_NONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Done and read data appear in the same cycle the memory presents its data.
  assign bus.int_done  = w_last && (r_owner == OWN_INT);
  assign bus.dm_done   = w_last && (r_owner == OWN_DM);
  assign bus.if_done   = w_last && (r_owner == OWN_IF);
  assign bus.rdata     = w_last ? bus.m_rdata : r_rdata;
  assign bus.int_stall = bus.int_req & ~bus.int_done;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;
  assign bus.if_stall  = bus.if_req & ~bus.if_done;
  assign bus.m_en      = r_m_en;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter at MEM_LAT 1 and 3
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  typedef struct {
    int         own;
    logic [7:0] data;
    bit         chk_data;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b3 ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .STARVE_MAX(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  // Memory models: unwritten locations read as addr ^ B5.
  logic [7:0]   mem1 [0:255];
  logic [7:0]   mem3 [0:255];
  logic [255:0] val1;
  logic [255:0] val3;
  logic [7:0]   pipe1;
  logic [7:0]   pipe3 [0:2];

  always @(posedge clk) begin
    if (!rst) begin
      val1 <= '0;
      val3 <= '0;
    end else begin
      if (b1.m_en && b1.m_we) begin
        mem1[b1.m_addr] <= b1.m_wdata;
        val1[b1.m_addr] <= 1'b1;
      end
      if (b3.m_en && b3.m_we) begin
        mem3[b3.m_addr] <= b3.m_wdata;
        val3[b3.m_addr] <= 1'b1;
      end
    end
    pipe1    <= val1[b1.m_addr] ? mem1[b1.m_addr] : (b1.m_addr ^ 8'hB5);
    pipe3[0] <= val3[b3.m_addr] ? mem3[b3.m_addr] : (b3.m_addr ^ 8'hB5);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign b1.m_rdata = pipe1;
  assign b3.m_rdata = pipe3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] dones(input int sel);
    return (sel == 1) ? {b1.if_done, b1.dm_done, b1.int_done}
                      : {b3.if_done, b3.dm_done, b3.int_done};
  endfunction

  task automatic wait_done(input int sel, output int at, output int men_at, output logic we_at);
    logic [2:0] d;
    int         n;
    int         own;
    exp_t       e;
    d = '0; n = 0; men_at = -1; we_at = 1'b0;
    e.own = 0; e.data = '0; e.chk_data = 1'b0;
    while (d == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
      if ((sel == 1) ? b1.m_en : b3.m_en) begin
        men_at = cyc;
        we_at  = (sel == 1) ? b1.m_we : b3.m_we;
      end
      d = dones(sel);
    end
    at = cyc;
    chk("done_seen", 32'(d != 3'b000), 1);
    if (d != 3'b000) begin
      own = d[0] ? 1 : (d[1] ? 2 : 3);
      chk("done_onehot", $countones(d), 1);
      if (q.size() > 0) e = q.pop_front();
      chk("owner", own, e.own);
      if (e.chk_data) chk("rdata", 32'((sel == 1) ? b1.rdata : b3.rdata), 32'(e.data));
    end
  endtask

  initial begin
    int   c0, at, ma;
    logic wa;
    {b1.int_req, b1.dm_req, b1.dm_we, b1.if_req} = '0;
    {b1.int_addr, b1.dm_addr, b1.dm_wdata, b1.if_addr} = '0;
    {b3.int_req, b3.dm_req, b3.dm_we, b3.if_req} = '0;
    {b3.int_addr, b3.dm_addr, b3.dm_wdata, b3.if_addr} = '0;

    repeat (3) @(negedge clk);
    chk("rst_m_en", 32'({b1.m_en, b3.m_en}), 0);
    chk("rst_m_we", 32'({b1.m_we, b3.m_we}), 0);
    chk("rst_busy", 32'({b1.busy, b3.busy}), 0);
    chk("rst_dones", 32'({dones(1), dones(3)}), 0);
    chk("rst_m_addr", 32'({b1.m_addr, b3.m_addr}), 0);
    chk("rst_m_wdata", 32'({b1.m_wdata, b3.m_wdata}), 0);
    chk("rst_rdata", 32'({b1.rdata, b3.rdata}), 0);
    rst = 1'b1;

    // Single IF read
    step; c0 = cyc;
    b1.if_req = 1'b1; b1.if_addr = 8'h10;
    q.push_back('{3, 8'hA5, 1'b1});
    @(negedge clk);
    chk("t1_stall_c0", 32'(b1.if_stall), 1);
    chk("t1_men_c0", 32'(b1.m_en), 0);
    @(negedge clk);
    chk("t1_men_c1", 32'(b1.m_en), 1);
    chk("t1_addr_c1", 32'(b1.m_addr), 'h10);
    chk("t1_we_c1", 32'(b1.m_we), 0);
    chk("t1_stall_c1", 32'(b1.if_stall), 1);
    wait_done(1, at, ma, wa);
    chk("t1_done_cyc", at - c0, 2);
    chk("t1_stall_done", 32'(b1.if_stall), 0);
    step; b1.if_req = 1'b0;

    // Simultaneous INT/DM/IF
    step; c0 = cyc;
    b1.int_req = 1'b1; b1.int_addr = 8'h01;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 8'h02;
    b1.if_req = 1'b1; b1.if_addr = 8'h03;
    q.push_back('{1, 8'hB4, 1'b1});
    q.push_back('{2, 8'hB7, 1'b1});
    q.push_back('{3, 8'hB6, 1'b1});
    for (int k = 0; k < 3; k++) begin
      wait_done(1, at, ma, wa);
      chk("t2_men_cyc", ma - c0, 1 + 3 * k);
      chk("t2_done_cyc", at - c0, 2 + 3 * k);
      step;
      if (k == 0) b1.int_req = 1'b0;
      else if (k == 1) b1.dm_req = 1'b0;
      else b1.if_req = 1'b0;
    end

    // DM write then read back
    step;
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 8'h20; b1.dm_wdata = 8'h3C;
    q.push_back('{2, 8'h00, 1'b0});
    wait_done(1, at, ma, wa);
    chk("t3_we_write", 32'(wa), 1);
    step; b1.dm_we = 1'b0; b1.dm_wdata = 8'h00;
    q.push_back('{2, 8'h3C, 1'b1});
    wait_done(1, at, ma, wa);
    chk("t3_we_read", 32'(wa), 0);
    step; b1.dm_req = 1'b0;

    // Starvation boost
    step;
    b1.dm_req = 1'b1; b1.dm_addr = 8'h30;
    b1.if_req = 1'b1; b1.if_addr = 8'h31;
    for (int k = 0; k < 3; k++) q.push_back('{2, 8'h85, 1'b1});
    q.push_back('{3, 8'h84, 1'b1});
    for (int k = 0; k < 4; k++) begin
      wait_done(1, at, ma, wa);
      if (k == 2) chk("t4_cnt_sat", 32'(dut1.u_arb.r_starve_cnt), 3);
      if (k == 3) chk("t4_cnt_clr", 32'(dut1.u_arb.r_starve_cnt), 0);
      step;
      if (k == 3) begin
        b1.dm_req = 1'b0;
        b1.if_req = 1'b0;
      end
    end

    // MEM_LAT=3 with DM arriving mid-WAIT
    step; c0 = cyc;
    b3.if_req = 1'b1; b3.if_addr = 8'h10;
    q.push_back('{3, 8'hA5, 1'b1});
    @(negedge clk);
    @(negedge clk);
    chk("t5_men_c1", 32'(b3.m_en), 1);
    step; step;
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 8'h40;
    q.push_back('{2, 8'hF5, 1'b1});
    wait_done(3, at, ma, wa);
    chk("t5_if_done_cyc", at - c0, 4);
    chk("t5_dm_stall", 32'(b3.dm_stall), 1);
    step; b3.if_req = 1'b0;
    wait_done(3, at, ma, wa);
    chk("t5_dm_men_cyc", ma - c0, 6);
    chk("t5_dm_done_cyc", at - c0, 9);
    step; b3.dm_req = 1'b0;

    // Reset mid-transaction
    step;
    b3.if_req = 1'b1; b3.if_addr = 8'h50;
    step;
    b1.if_req = 1'b1; b1.if_addr = 8'h51;
    step;
    rst = 1'b0;
    b1.if_req = 1'b0; b3.if_req = 1'b0;
    #1;
    chk("t6_busy3", 32'(b3.busy), 0);
    chk("t6_men1", 32'(b1.m_en), 0);
    chk("t6_busy1", 32'(b1.busy), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_no_done", 32'({dones(1), dones(3)}), 0);
    end
    rst = 1'b1;
    step; c0 = cyc;
    b3.if_req = 1'b1; b3.if_addr = 8'h10;
    q.push_back('{3, 8'hA5, 1'b1});
    wait_done(3, at, ma, wa);
    chk("t6_after_rst_done", at - c0, 4);
    step; b3.if_req = 1'b0;

    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory of the 8-bit pipelined processor among three requesters:
  - interrupt vector/PC fetch (INT)
  - MEM-stage data access (DM)
  - instruction fetch (IF)
- Non-pipelined, one transaction in flight. Fixed priority INT > DM > IF, with an anti-starvation boost for IF.
- Drives the memory macro and returns per-requester stall/done to the fetch, memory and hazard logic.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..3.
- STARVE_MAX, 3, number of consecutive lost arbitrations after which IF outranks DM; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- int_req  in  1  INT read request, level, held until int_done
- int_addr  in  ADDR_W  INT read address
- dm_req  in  1  DM request, level, held until dm_done
- dm_we  in  1  DM write enable (1 = write, 0 = read)
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- if_req  in  1  IF read request, level, held until if_done
- if_addr  in  ADDR_W  IF read address
- int_done, dm_done, if_done  out  1 each  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid only in the cycle a done pulse is high
- int_stall, dm_stall, if_stall  out  1 each  stall = req & ~done (combinational)
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en
- busy  out  1  a transaction is in flight

Behaviour:
- Clock and reset: reset rst, asynchronous, active-low; clock clk.
- Reset values:
  - FSM = IDLE.
  - All done pulses, m_en, m_we and busy = 0.
  - m_addr, m_wdata, rdata = 0.
  - Latency counter and starvation counter = 0; owner register = none.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE: arbitrate among asserted requests. If any request is present, register the owner, drive m_en=1 together with m_addr/m_we/m_wdata from the winner, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (the m_en cycle): load the latency counter with MEM_LAT-1 and go to WAIT.
  - WAIT: when the counter reaches 0, capture m_rdata into rdata, pulse the owner's done for one cycle, clear the owner and return to IDLE. Otherwise decrement the counter.
- Registered-output timing: m_en is registered, asserted in the cycle after arbitration.
  - Done occurs MEM_LAT cycles after the m_en cycle.
  - Request-to-done = MEM_LAT+1 cycles, e.g. 2 cycles for MEM_LAT=1.
  - Minimum spacing between m_en strobes = MEM_LAT+2 cycles. Arbitration only happens in IDLE.
- Writes (DM with dm_we=1) follow the same timing; rdata is don't-care on a write done. INT and IF never write (m_we=0).
- Priority: INT > DM > IF.
  - The starvation counter increments each arbitration where if_req=1 and IF loses.
  - When the counter reaches STARVE_MAX, IF outranks DM, but never INT.
  - The counter clears when IF is granted or if_req=0. It saturates at STARVE_MAX.
- Simultaneous events:
  - A request rising during a transaction waits for the next IDLE.
  - The owner's done pulse and a new request from another requester in the same cycle: the new request is arbitrated next cycle, in IDLE.
- Protocol violations:
  - A requester dropping req mid-transaction: the access still completes and done still pulses (harmless).
  - Address/data changes after grant are ignored, because they were latched at grant.
- Stalls are combinational from req and done so that the hazard unit sees them in the same cycle.
- Reset mid-transaction: immediate return to IDLE, no done pulse, m_en deasserted asynchronously.

Decomposition:
- Shared package (cpu_pkg): requester ID encoding (OWN_NONE=0, OWN_INT=1, OWN_DM=2, OWN_IF=3), FSM state encoding, and the default ADDR_W/DATA_W.
- One sub-module: arb_prio_starve. This is the combinational priority select plus the registered starvation counter; it outputs the one-hot grant.

Test Plan:
- Single IF read, MEM_LAT=1, if_addr=8'h10, memory holds 8'hA5:
  - m_en high at cycle 1 with m_addr=10.
  - if_done pulses at cycle 2 with rdata=A5.
  - if_stall is high in cycles 0–1.
- Simultaneous int_req/dm_req/if_req at cycle 0, MEM_LAT=1:
  - Grant order is INT, DM, IF.
  - m_en at cycles 1, 4, 7; dones at 2, 5, 8.
- DM write dm_addr=8'h20, dm_wdata=8'h3C, then DM read of 8'h20 → m_we=1 only on the first strobe; the read returns 3C.
- STARVE_MAX=3, dm_req held continuously and if_req held → after 3 consecutive DM grants, the 4th grant goes to IF and the starvation counter clears to 0.
- MEM_LAT=3, IF read → done occurs 3 cycles after m_en.
  - Assert dm_req mid-WAIT → DM is granted only after if_done, with the next m_en 2 cycles after if_done.
- Deassert rst during WAIT → the same cycle shows m_en/busy=0, no done pulse follows, and a new if_req is served normally after reset is released.
